// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin UART TX arbiter with message locking and RX steering (optional lock timeout: UART_ARB_TIMEOUT_EN)
module uart_tx_arbiter #(
  parameter int                    data_width     = 8,
  parameter logic [data_width-1:0] eol_char       = data_width'(8'h0A),
  parameter int                    timeout_cycles = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] m0_wdata,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  input  logic [data_width-1:0] m1_wdata,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [data_width-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [data_width-1:0] rdata,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic                  rx_sel,
  output logic                  s0_rvalid,
  output logic                  s1_rvalid,
  input  logic                  s0_rready,
  input  logic                  s1_rready,
  output logic [1:0]            grant,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [15:0] tmo_limit = 16'(timeout_cycles - 1);

  state_t state;
  state_t state_next;
  logic   last;
  logic   rx_owner;
  logic   tx_hs;
  logic   eol_hs;
  logic   timeout_hit;
  logic   release_lock;

  assign tx_hs        = wvalid & wready;
  assign eol_hs       = tx_hs && (wdata == eol_char);
  assign release_lock = eol_hs || timeout_hit;

  // Consumers take the RX byte straight from the UART; only the handshake is steered here.
  logic unused_rdata;
  assign unused_rdata = ^rdata;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Stall counter: restarts on every grant and every accepted byte, counts idle owned cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE || tx_hs || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state != IDLE) && !tx_hs && (tmo_cnt == tmo_limit);
`else
  logic unused_cfg;
  assign unused_cfg  = ^tmo_limit;
  assign timeout_hit = 1'b0;
`endif

  assign timeout = timeout_hit;

  // State register; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Remember which port finished last so a tie goes to the other one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last <= 1'b1;
    end else if (release_lock && state == OWN0) begin
      last <= 1'b0;
    end else if (release_lock && state == OWN1) begin
      last <= 1'b1;
    end
  end

  // Next-state: round-robin pick in IDLE, hold lock until EOL or timeout.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_wvalid && m1_wvalid) begin
          state_next = last ? OWN0 : OWN1;
        end else if (m0_wvalid) begin
          state_next = OWN0;
        end else if (m1_wvalid) begin
          state_next = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (release_lock) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs: owner's stream passes straight through, the other port is held off.
  always_comb begin
    grant     = 2'b00;
    wdata     = '0;
    wvalid    = 1'b0;
    m0_wready = 1'b0;
    m1_wready = 1'b0;
    case (state)
      OWN0: begin
        grant     = 2'b01;
        wdata     = m0_wdata;
        wvalid    = m0_wvalid;
        m0_wready = wready;
      end
      OWN1: begin
        grant     = 2'b10;
        wdata     = m1_wdata;
        wvalid    = m1_wvalid;
        m1_wready = wready;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  // RX owner only changes when no byte is on offer or the current one is consumed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_owner <= 1'b0;
    end else if (!rvalid || rready) begin
      rx_owner <= rx_sel;
    end
  end

  assign s0_rvalid = rvalid & ~rx_owner;
  assign s1_rvalid = rvalid & rx_owner;
  assign rready    = rx_owner ? s1_rready : s0_rready;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int HOLD_CYCLES = 5;
`else
  localparam int HOLD_CYCLES = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] m0_wdata, m1_wdata, wdata, rdata;
  logic       m0_wvalid, m0_wready, m1_wvalid, m1_wready;
  logic       wvalid, wready, rvalid, rready, rx_sel;
  logic       s0_rvalid, s1_rvalid, s0_rready, s1_rready;
  logic [1:0] grant;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  uart_tx_arbiter #(
    .data_width(8),
    .eol_char(8'h0A),
    .timeout_cycles(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_wdata(m0_wdata), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
    .m1_wdata(m1_wdata), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .rx_sel(rx_sel),
    .s0_rvalid(s0_rvalid), .s1_rvalid(s1_rvalid),
    .s0_rready(s0_rready), .s1_rready(s1_rready),
    .grant(grant), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b0;
    m0_wvalid = 1'b0; m1_wvalid = 1'b0; m0_wdata = 8'h00; m1_wdata = 8'h00;
    wready = 1'b1; rvalid = 1'b0; rx_sel = 1'b0; rdata = 8'h00;
    s0_rready = 1'b0; s1_rready = 1'b0;
    tick; tick;
    rst = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    rst = 1'b0;
    rvalid = 1'b1;
    settle;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", grant); end
    n_tests++; if (wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_wvalid: got %b want 0", wvalid); end
    n_tests++; if (m0_wready !== 1'b0 || m1_wready !== 1'b0) begin n_fail++; $display("FAIL reset_wready: got %b%b want 00", m0_wready, m1_wready); end
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    n_tests++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_owner: got s0=%b s1=%b want s0=1 s1=0", s0_rvalid, s1_rvalid); end
    rvalid = 1'b0;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_single;
    do_reset;
    tick;
    m1_wvalid = 1'b1; m1_wdata = 8'h48;
    settle;
    n_tests++; if (grant !== 2'b00 || wvalid !== 1'b0 || m1_wready !== 1'b0) begin n_fail++; $display("FAIL single_idle: got grant=%b wvalid=%b m1_wready=%b want 00/0/0", grant, wvalid, m1_wready); end
    tick;
    settle;
    n_tests++; if (grant !== 2'b10) begin n_fail++; $display("FAIL single_grant: got %b want 10", grant); end
    n_tests++; if (wdata !== 8'h48 || wvalid !== 1'b1 || m1_wready !== 1'b1 || m0_wready !== 1'b0) begin n_fail++; $display("FAIL single_byte0: got %h v=%b r1=%b r0=%b want 48/1/1/0", wdata, wvalid, m1_wready, m0_wready); end
    tick;
    m1_wdata = 8'h69;
    settle;
    n_tests++; if (wdata !== 8'h69 || grant !== 2'b10) begin n_fail++; $display("FAIL single_byte1: got %h grant=%b want 69/10", wdata, grant); end
    tick;
    m1_wdata = 8'h0A;
    settle;
    n_tests++; if (wdata !== 8'h0A || grant !== 2'b10) begin n_fail++; $display("FAIL single_byte2: got %h grant=%b want 0a/10", wdata, grant); end
    tick;
    m1_wvalid = 1'b0;
    settle;
    n_tests++; if (grant !== 2'b00 || wvalid !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant=%b wvalid=%b want 00/0", grant, wvalid); end
  endtask

  task automatic test_tie;
    do_reset;
    tick;
    m0_wvalid = 1'b1; m0_wdata = 8'h31;
    m1_wvalid = 1'b1; m1_wdata = 8'h55;
    tick;
    settle;
    n_tests++; if (grant !== 2'b01 || wdata !== 8'h31) begin n_fail++; $display("FAIL tie_first: got grant=%b wdata=%h want 01/31", grant, wdata); end
    n_tests++; if (m1_wready !== 1'b0 || m0_wready !== 1'b1) begin n_fail++; $display("FAIL tie_ready: got r0=%b r1=%b want 1/0", m0_wready, m1_wready); end
    tick;
    m0_wdata = 8'h0A;
    tick;
    m0_wdata = 8'h32;
    settle;
    n_tests++; if (grant !== 2'b00 || m1_wready !== 1'b0) begin n_fail++; $display("FAIL tie_gap: got grant=%b r1=%b want 00/0", grant, m1_wready); end
    tick;
    settle;
    n_tests++; if (grant !== 2'b10 || wdata !== 8'h55) begin n_fail++; $display("FAIL tie_second: got grant=%b wdata=%h want 10/55", grant, wdata); end
    m1_wdata = 8'h0A;
    tick;
    settle;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL tie_gap2: got grant=%b want 00", grant); end
    tick;
    settle;
    n_tests++; if (grant !== 2'b01 || wdata !== 8'h32) begin n_fail++; $display("FAIL tie_rr: got grant=%b wdata=%h want 01/32", grant, wdata); end
    m1_wvalid = 1'b0;
    m0_wdata = 8'h0A;
    tick;
    m0_wvalid = 1'b0;
    tick;
  endtask

  task automatic test_lock_hold;
    do_reset;
    tick;
    m0_wvalid = 1'b1; m0_wdata = 8'h41;
    tick;
    m1_wvalid = 1'b1; m1_wdata = 8'h77;
    settle;
    n_tests++; if (grant !== 2'b01 || wdata !== 8'h41) begin n_fail++; $display("FAIL lock_own: got grant=%b wdata=%h want 01/41", grant, wdata); end
    tick;
    m0_wvalid = 1'b0;
    for (int i = 0; i < HOLD_CYCLES; i++) begin
      settle;
      n_tests++; if (grant !== 2'b01 || m1_wready !== 1'b0 || wvalid !== 1'b0) begin n_fail++; $display("FAIL lock_hold[%0d]: got grant=%b r1=%b wvalid=%b want 01/0/0", i, grant, m1_wready, wvalid); end
      tick;
    end
    m0_wvalid = 1'b1; m0_wdata = 8'h0A;
    tick;
    m0_wvalid = 1'b0;
    settle;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL lock_release: got grant=%b want 00", grant); end
    tick;
    settle;
    n_tests++; if (grant !== 2'b10 || wdata !== 8'h77) begin n_fail++; $display("FAIL lock_next: got grant=%b wdata=%h want 10/77", grant, wdata); end
    m1_wdata = 8'h0A;
    tick;
    m1_wvalid = 1'b0;
    tick;
  endtask

  task automatic test_backpressure;
    do_reset;
    tick;
    wready = 1'b0;
    m1_wvalid = 1'b1; m1_wdata = 8'h5A;
    tick;
    for (int i = 0; i < 5; i++) begin
      settle;
      n_tests++; if (m1_wready !== 1'b0 || wdata !== 8'h5A || wvalid !== 1'b1 || grant !== 2'b10) begin n_fail++; $display("FAIL bp_stall[%0d]: got r1=%b wdata=%h v=%b grant=%b want 0/5a/1/10", i, m1_wready, wdata, wvalid, grant); end
      tick;
    end
    wready = 1'b1;
    settle;
    n_tests++; if (m1_wready !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got r1=%b want 1", m1_wready); end
    tick;
    m1_wdata = 8'h0A;
    settle;
    n_tests++; if (grant !== 2'b10 || wdata !== 8'h0A) begin n_fail++; $display("FAIL bp_kept: got grant=%b wdata=%h want 10/0a", grant, wdata); end
    tick;
    m1_wvalid = 1'b0;
    settle;
    n_tests++; if (grant !== 2'b00) begin n_fail++; $display("FAIL bp_release: got grant=%b want 00", grant); end
  endtask

  task automatic test_rx_steer;
    do_reset;
    tick;
    rvalid = 1'b1; rdata = 8'hC3; rx_sel = 1'b1;
    settle;
    n_tests++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL rx_pending: got s0=%b s1=%b rready=%b want 1/0/0", s0_rvalid, s1_rvalid, rready); end
    tick;
    settle;
    n_tests++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rx_no_resteer: got s0=%b s1=%b want 1/0", s0_rvalid, s1_rvalid); end
    s1_rready = 1'b1;
    settle;
    n_tests++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rx_wrong_ready: got rready=%b want 0", rready); end
    s0_rready = 1'b1;
    settle;
    n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rx_s0_ready: got rready=%b want 1", rready); end
    tick;
    rdata = 8'h3C; s0_rready = 1'b0; s1_rready = 1'b0;
    settle;
    n_tests++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || rready !== 1'b0) begin n_fail++; $display("FAIL rx_next_s1: got s0=%b s1=%b rready=%b want 0/1/0", s0_rvalid, s1_rvalid, rready); end
    s1_rready = 1'b1;
    settle;
    n_tests++; if (rready !== 1'b1) begin n_fail++; $display("FAIL rx_s1_ready: got rready=%b want 1", rready); end
    tick;
    rvalid = 1'b0; s1_rready = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    do_reset;
    tick;
    m0_wvalid = 1'b1; m0_wdata = 8'h41;
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    m0_wvalid = 1'b0;
    settle;
    n_tests++; if (grant !== 2'b00 || wvalid !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got grant=%b wvalid=%b want 00/0", grant, wvalid); end
    tick;
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    tick;
    m0_wvalid = 1'b1; m0_wdata = 8'h41;
    m1_wvalid = 1'b1; m1_wdata = 8'h77;
    tick;
    m0_wvalid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      settle;
      n_tests++; if (timeout !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL tmo_early[%0d]: got timeout=%b grant=%b want 0/01", k, timeout, grant); end
      tick;
    end
    settle;
    n_tests++; if (timeout !== 1'b1 || grant !== 2'b01) begin n_fail++; $display("FAIL tmo_pulse: got timeout=%b grant=%b want 1/01", timeout, grant); end
    tick;
    settle;
    n_tests++; if (timeout !== 1'b0 || grant !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: got timeout=%b grant=%b want 0/00", timeout, grant); end
    tick;
    settle;
    n_tests++; if (grant !== 2'b10 || wdata !== 8'h77) begin n_fail++; $display("FAIL tmo_handover: got grant=%b wdata=%h want 10/77", grant, wdata); end
    m1_wdata = 8'h0A;
    tick;
    m1_wvalid = 1'b0;
    tick;
  endtask
`else
  task automatic test_timeout;
    do_reset;
    tick;
    m0_wvalid = 1'b1; m0_wdata = 8'h41;
    m1_wvalid = 1'b1; m1_wdata = 8'h77;
    tick;
    m0_wvalid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      settle;
      n_tests++; if (timeout !== 1'b0 || grant !== 2'b01) begin n_fail++; $display("FAIL notmo[%0d]: got timeout=%b grant=%b want 0/01", k, timeout, grant); end
      tick;
    end
    m0_wvalid = 1'b1; m0_wdata = 8'h0A;
    tick;
    m0_wvalid = 1'b0; m1_wvalid = 1'b0;
    tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_tie;
    test_lock_hold;
    test_backpressure;
    test_rx_steer;
    test_reset_mid;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit stream between two byte-stream requesters: port 0 is the echo path and port 1 is the µcmd FSM. Arbitration is round-robin with message locking. A grant is held until the owner sends the end-of-line character. The block also steers the UART receive stream to one of the two consumers. It sits between the `uart` instance and its clients in the top level, replacing the static echo multiplexer.

## Interface
Parameters:
- `data_width`, 8, byte width of all data buses.
- `eol_char`, 8'h0A, byte value that ends a locked message.
- `timeout_cycles`, 1024, stall limit for the lock timeout; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `m0_wdata`  in  data_width  byte offered by requester 0 (echo).
- `m0_wvalid`  in  1  requester 0 byte valid.
- `m0_wready`  out  1  requester 0 byte accepted.
- `m1_wdata`  in  data_width  byte offered by requester 1 (µcmd).
- `m1_wvalid`  in  1  requester 1 byte valid.
- `m1_wready`  out  1  requester 1 byte accepted.
- `wdata`  out  data_width  byte to the UART TX FIFO.
- `wvalid`  out  1  valid to the UART TX FIFO.
- `wready`  in  1  UART TX FIFO ready.
- `rdata`  in  data_width  byte from the UART RX FIFO; fanned out unchanged to both consumers.
- `rvalid`  in  1  UART RX byte valid.
- `rready`  out  1  UART RX byte consumed.
- `rx_sel`  in  1  requested RX consumer: 0 = echo, 1 = µcmd.
- `s0_rvalid`, `s1_rvalid`  out  1  RX valid to consumer 0 / 1.
- `s0_rready`, `s1_rready`  in  1  RX ready from consumer 0 / 1.
- `grant`  out  2  one-hot current TX owner; 2'b00 when idle.
- `timeout`  out  1  one-cycle pulse when a lock is force-released.

## Operation
- FSM states: IDLE, OWN0, OWN1. The `last` register records the most recently served port.
- **IDLE**
  - `wvalid`, `m0_wready` and `m1_wready` are all 0.
  - Only `m0_wvalid` set: go to OWN0 next cycle.
  - Only `m1_wvalid` set: go to OWN1 next cycle.
  - Both set: grant the port that is not `last`.
  - Neither set: stay in IDLE.
- **OWNn**
  - `wdata` = `mn_wdata`, `wvalid` = `mn_wvalid`, `mn_wready` = `wready`.
  - The other port's `wready` is 0.
- A handshake (`wvalid & wready`) carrying `wdata == eol_char` moves the FSM to IDLE and sets `last` = n.
- A handshake with any other byte keeps ownership.
- The owner dropping `wvalid` does not release the lock.
- RX steering:
  - The `rx_owner` register loads `rx_sel` only when `rvalid` == 0 or on an RX handshake. A byte already on offer is never re-steered.
  - `s{rx_owner}_rvalid` = `rvalid`; the other consumer's `rvalid` is 0.
  - `rready` = `s{rx_owner}_rready`.
- Reset values:
  - FSM = IDLE, `last` = 1, so port 0 wins the first tie.
  - `rx_owner` = 0, timeout counter = 0.
  - `grant` = 00, `timeout` = 0, `wvalid` = 0, `m0_wready` = `m1_wready` = 0.
- Reset asserted mid-message returns the FSM to IDLE on that edge. The partially sent message is abandoned; no byte is replayed.

## Timing
- Arbitration latency: a request seen in IDLE reaches the UART one cycle later, when `grant` becomes one-hot.
- Data path: `wdata`/`wvalid` and the ready signals are combinational from the owner's inputs, adding no latency while owned.
- Throughput while owned is one byte per cycle.
- After an EOL handshake, IDLE lasts exactly one cycle before the next grant. The minimum gap between messages from different ports is 1 cycle.
- A request arriving in the same cycle as an EOL release is evaluated in that following IDLE cycle.
- RX steering is fully combinational apart from the `rx_owner` register. `rx_sel` takes effect in the cycle after its sample condition is met.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to OWNn and on every TX handshake, and increments otherwise while in OWNn.
  - When it reaches `timeout_cycles-1`, the FSM goes to IDLE, `last` = n, and `timeout` pulses for one cycle.
  - This stops a stalled owner that never sends `eol_char` from blocking the other port.
- Undefined: no counter exists, `timeout` is tied to 0, and a lock is held until `eol_char` indefinitely.

## Test plan
- Single requester: m1 sends "Hi\n" (0x48, 0x69, 0x0A) with `wready`=1. Required: `grant`=10 one cycle after the request, three UART bytes on consecutive cycles, then `grant`=00.
- Tie after reset: m0 and m1 both assert. Required: m0 granted first; after its 0x0A is accepted, m1 is granted after one IDLE cycle.
- Lock hold: m0 owns and sends 0x41; m1 requests; m0 drops `wvalid` for 10 cycles. Required: `grant` stays 01, `m1_wready`=0, until m0 sends 0x0A.
- Backpressure: `wready`=0 for 5 cycles with m1 owning. Required: `m1_wready`=0 and `wdata` stable; the byte is accepted on the first `wready`=1 cycle.
- RX steering: `rvalid`=1 pending with `rx_owner`=0; `rx_sel` toggles to 1. Required: the byte is still delivered to s0; s1 receives the next byte.
- With `UART_ARB_TIMEOUT_EN` and `timeout_cycles`=8: m0 owns and stalls while m1 requests. Required: `timeout` pulses at stall cycle 8, followed by `grant`=10.
